// File: rtl/apb_slave_gen2_module.sv
// apb_slave_gen2_module: APB slave with byte strobes, handshaked memory port, timeout and write protection
module apb_slave_gen2_module #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter logic [4:0] RO_ADDR_A = 5'b01100,
  parameter logic [4:0] RO_ADDR_B = 5'b10000,
  parameter int MEM_TIMEOUT = 16,
  localparam int STRB_WIDTH = BUS_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [STRB_WIDTH-1:0] pstrb_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  start_bit_i,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  busy_o,
  output logic                  err_sticky_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BUS_WIDTH-1:0]  mem_wdata_o,
  output logic [STRB_WIDTH-1:0] mem_strb_o,
  input  logic                  mem_ack_i,
  input  logic [BUS_WIDTH-1:0]  mem_rdata_i
);
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  if (BUS_WIDTH % 8 != 0 || DATA_WIDTH < 1) begin : g_bad_width
    $error("BUS_WIDTH must be a multiple of 8 and DATA_WIDTH positive");
  end
  typedef enum logic [1:0] {IDLE, CHECK, MEM_WAIT, RESP} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic we_q;
  logic err_q;
  logic [CW-1:0] cnt;
  logic req_err;
  logic tmo_hit;
  // request rejection and timeout decisions from captured request and counter
  always_comb begin
    req_err = (!we_q && |strb_q) || (we_q && (addr_q[4:0] == RO_ADDR_A || addr_q[4:0] == RO_ADDR_B)) || start_bit_i;
    tmo_hit = (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT - 1));
  end
  // transfer FSM with capture, response data and error flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
      prdata_o <= '0;
      err_sticky_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (psel_i) begin
          addr_q <= paddr_i;
          we_q <= pwrite_i;
          strb_q <= pstrb_i;
          wdata_q <= pwdata_i;
          prdata_o <= '0;
          err_q <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          cnt <= '0;
          if (!psel_i) begin
            err_sticky_o <= 1'b1;
            state <= IDLE;
          end else if (req_err) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (!psel_i) begin
            err_sticky_o <= 1'b1;
            state <= IDLE;
          end else if (mem_ack_i) begin
            if (!we_q) prdata_o <= mem_rdata_i;
            state <= RESP;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            prdata_o <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (!psel_i) begin
            err_sticky_o <= 1'b1;
            state <= IDLE;
          end else if (penable_i) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
  // status and memory port outputs decoded from registered state
  always_comb begin
    pready_o = state == RESP;
    pslverr_o = state == RESP && err_q;
    busy_o = state != IDLE;
    mem_req_o = state == MEM_WAIT;
    mem_we_o = we_q;
    mem_addr_o = addr_q;
    mem_wdata_o = wdata_q;
    mem_strb_o = we_q ? strb_q : '0;
  end
endmodule

// File: tb/tb_apb_slave_gen2_module.sv
// tb_apb_slave_gen2_module: randomized APB master and memory responder against a transaction-level model
module tb_apb_slave_gen2_module;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0, start_bit = 1'b0;
  logic [7:0] pstrb = '0;
  logic [63:0] pwdata = '0, mem_rdata = '0, prdata;
  logic [31:0] paddr = '0, mem_addr;
  logic pready, pslverr, busy, err_sticky, mem_req, mem_we, mem_ack = 1'b0;
  logic [63:0] mem_wdata;
  logic [7:0] mem_strb;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  apb_slave_gen2_module dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .pstrb_i(pstrb), .pwdata_i(pwdata), .paddr_i(paddr), .start_bit_i(start_bit),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr), .busy_o(busy),
    .err_sticky_o(err_sticky), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic outputs_zero(input string tag);
    check(tag, 64'(|{prdata, pready, pslverr, busy, err_sticky, mem_req, mem_we, mem_addr, mem_wdata, mem_strb}), 64'd0);
  endtask
  // caller is at a negedge; returns at the negedge after completion with psel dropped
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [7:0] strb, input logic [63:0] wd,
                      input int smode, input int wn, input logic [63:0] rd);
    logic err, exp_slv, done;
    logic [63:0] exp_rd;
    int exp_mc, cyc, reqc;
    err = (!we && strb != 0) || (we && (addr[4:0] == 5'h0C || addr[4:0] == 5'h10)) || smode == 1;
    exp_mc = err ? 0 : (wn < 16 ? wn + 1 : 16);
    exp_slv = err || wn >= 16;
    exp_rd = (exp_slv || we) ? 64'd0 : rd;
    psel = 1'b1; penable = 1'b0; pwrite = we; paddr = addr; pstrb = strb; pwdata = wd;
    start_bit = smode == 1; mem_ack = 1'b0;
    cyc = 1; reqc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      penable = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mem_req) begin
        reqc++;
        check("mem_we", 64'(mem_we), 64'(we));
        check("mem_addr", 64'(mem_addr), 64'(addr));
        check("mem_wdata", mem_wdata, wd);
        check("mem_strb", 64'(mem_strb), we ? 64'(strb) : 64'd0);
        if (smode == 2) start_bit = 1'b1;
        if (reqc == wn + 1) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
      end else if ($urandom_range(3) == 0) begin
        mem_ack = 1'b1;
      end
      if (!pready) check("slverr_idle", 64'(pslverr), 64'd0);
      done = pready;
    end
    check("ready", 64'(done), 64'd1);
    check("latency", 64'(cyc), 64'(3 + exp_mc));
    check("memreq_cycles", 64'(reqc), 64'(exp_mc));
    check("slverr", 64'(pslverr), 64'(exp_slv));
    check("prdata", prdata, exp_rd);
    check("sticky", 64'(err_sticky), 64'd0);
    mem_ack = 1'b0;
    start_bit = 1'b0;
    @(negedge clk);
    check("done_busy", 64'(busy), 64'd0);
    check("done_ready", 64'(pready), 64'd0);
    psel = 1'b0;
    penable = 1'b0;
  endtask
  task automatic open_to_wait(input int n);
    int reqc;
    reqc = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20; pstrb = 8'h00;
    for (int i = 0; i < 20 && reqc < n; i++) begin
      @(negedge clk);
      penable = 1'b1;
      if (mem_req) reqc++;
    end
    check("reach_wait", 64'(reqc), 64'(n));
  endtask
  initial begin
    logic [31:0] a;
    logic [7:0] s;
    logic w;
    repeat (3) @(negedge clk);
    outputs_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    outputs_zero("idle_outputs");
    xfer(1'b1, 32'h04, 8'h0F, 64'h1122334455667788, 0, 0, 64'd0);
    xfer(1'b0, 32'h08, 8'h00, 64'd0, 0, 3, 64'hDEADBEEFCAFEF00D);
    xfer(1'b1, 32'h0C, 8'hFF, 64'h55, 0, 0, 64'd0);
    xfer(1'b1, 32'h10, 8'hFF, 64'h66, 0, 0, 64'd0);
    xfer(1'b0, 32'h08, 8'h01, 64'd0, 0, 0, 64'h77);
    xfer(1'b0, 32'h14, 8'h00, 64'd0, 1, 0, 64'h88);
    xfer(1'b0, 32'h14, 8'h00, 64'd0, 2, 2, 64'h0123456789ABCDEF);
    xfer(1'b0, 32'h18, 8'h00, 64'd0, 0, 15, 64'hA5A5A5A5A5A5A5A5);
    xfer(1'b0, 32'h1C, 8'h00, 64'd0, 0, 19, 64'hFFFF);
    mem_ack = 1'b1;
    mem_rdata = 64'hBAD0BAD0BAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_prdata", prdata, 64'd0);
    check("late_ack_busy", 64'(busy), 64'd0);
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(1));
      a = $urandom;
      if ($urandom_range(2) == 0) a[4:0] = $urandom_range(1) ? 5'h0C : 5'h10;
      s = ($urandom_range(3) == 0 || w) ? 8'($urandom) : 8'h00;
      xfer(w, a, s, {$urandom, $urandom}, $urandom_range(5) < 4 ? 0 : int'($urandom_range(2)),
           int'($urandom_range(19)), {$urandom, $urandom});
    end
    open_to_wait(3);
    psel = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check("abort_req", 64'(mem_req), 64'd0);
    check("abort_ready", 64'(pready), 64'd0);
    check("abort_sticky", 64'(err_sticky), 64'd1);
    repeat (5) @(negedge clk);
    check("sticky_hold", 64'(err_sticky), 64'd1);
    open_to_wait(2);
    rst = 1'b1;
    @(negedge clk);
    outputs_zero("reset_mid_wait");
    rst = 1'b0;
    psel = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    outputs_zero("after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_slave_gen2_module.md
Name: apb_slave_gen2_module

Overview:
Second-generation APB slave for the matmul register/memory space. It adds byte-granular strobes, a registered request/acknowledge memory port with variable wait states and a timeout, and two parametrised write-protected addresses. A sticky protocol-error flag is also provided. It sits between the APB master and the matmul register file/SRAM, replacing the combinational bus_mem pass-through with a handshaked port.

Parameters:
DATA_WIDTH, 32, matrix element width (informational, used for MAX_DIM)
BUS_WIDTH, 64, APB data width; multiple of 8
ADDR_WIDTH, 32, APB address width
STRB_WIDTH, BUS_WIDTH/8, one strobe bit per byte (localparam)
RO_ADDR_A, 5'b01100, paddr[4:0] of write-protected FLAGS register
RO_ADDR_B, 5'b10000, paddr[4:0] of write-protected SP register
MEM_TIMEOUT, 16, max MEM_WAIT cycles before error; 0 = no timeout

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active high
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  1 = write, 0 = read
pstrb_i  in  STRB_WIDTH  byte strobes
pwdata_i  in  BUS_WIDTH  write data
paddr_i  in  ADDR_WIDTH  address
start_bit_i  in  1  engine running; locks out new accesses
prdata_o  out  BUS_WIDTH  read data, registered
pready_o  out  1  transfer complete
pslverr_o  out  1  transfer error, valid with pready_o
busy_o  out  1  state != IDLE
err_sticky_o  out  1  set on aborted transfer, cleared only by reset
mem_req_o  out  1  memory request, high in MEM_WAIT
mem_we_o  out  1  captured pwrite
mem_addr_o  out  ADDR_WIDTH  captured paddr
mem_wdata_o  out  BUS_WIDTH  captured pwdata
mem_strb_o  out  STRB_WIDTH  captured pstrb on write, 0 on read
mem_ack_i  in  1  memory completes request (single-cycle pulse)
mem_rdata_i  in  BUS_WIDTH  read data, valid with mem_ack_i

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE. All outputs 0, capture regs 0, timeout counter 0, err_sticky_o=0. Reset mid-transfer aborts without pready_o and drops mem_req_o after the edge.
- FSM states: IDLE, CHECK, MEM_WAIT, RESP. All outputs decode from registers; no combinational input-to-output path.
- IDLE:
  - psel_i=1 → capture paddr, pwrite, pstrb, pwdata; clear prdata_o; clear err flag reg; go to CHECK.
  - Otherwise stay in IDLE.
- CHECK:
  - psel_i=0 → abort: go to IDLE, set err_sticky_o.
  - Error conditions:
    - read with captured pstrb != 0;
    - write with captured addr[4:0] == RO_ADDR_A or RO_ADDR_B;
    - start_bit_i=1.
  - Any error → set err reg, go to RESP; no memory request is issued.
  - No error → go to MEM_WAIT, counter=0.
- MEM_WAIT:
  - mem_req_o=1; mem_* outputs are stable for the whole state.
  - psel_i=0 → abort: go to IDLE, set err_sticky_o.
  - mem_ack_i=1 → on a read, prdata_o<=mem_rdata_i; go to RESP.
  - No ack → counter++. When MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with no ack, set err reg, prdata_o=0, go to RESP.
  - An ack in the MEM_TIMEOUT-th cycle is accepted.
  - Counter width is clog2(MEM_TIMEOUT+1).
  - start_bit_i changes here are ignored; the transfer is already accepted.
- RESP:
  - pready_o=1 and pslverr_o=err reg; pslverr_o is 0 whenever pready_o is 0.
  - Leave to IDLE on psel_i&penable_i (transfer complete). Otherwise hold with pready_o high.
  - psel_i=0 → IDLE, set err_sticky_o.
- Latency: minimum 4 cycles from setup to completion cycle (setup, CHECK, MEM_WAIT with immediate ack, RESP). Error path takes 3 cycles. Back-to-back: a new setup is accepted in the IDLE cycle following RESP.
- mem_ack_i outside MEM_WAIT is ignored. Late acks after a timeout are discarded.
- busy_o=1 in CHECK, MEM_WAIT and RESP.

Test Plan:
- Reset then write addr 0x04, pwdata 0x1122334455667788, pstrb 8'h0F, ack on first MEM_WAIT cycle → mem_req_o high 1 cycle, mem_strb_o=0x0F, mem_wdata_o matches; pready_o=1, pslverr_o=0 on cycle 4.
- Read addr 0x08, ack after 3 wait cycles with rdata 0xDEADBEEFCAFEF00D → mem_strb_o=0, prdata_o=0xDEADBEEFCAFEF00D with pready_o on cycle 7, pslverr_o=0.
- Write to addr 0x0C (FLAGS) and to 0x10 (SP); separately, read with pstrb=8'h01 → mem_req_o never asserts; pready_o=1, pslverr_o=1 on cycle 3 for each.
- start_bit_i=1 during CHECK → error response, no mem_req_o. start_bit_i rising during MEM_WAIT → transfer completes normally.
- MEM_TIMEOUT=16, no ack → mem_req_o high exactly 16 cycles, then pready_o=1, pslverr_o=1, prdata_o=0. A subsequent late ack is ignored.
- psel_i dropped during MEM_WAIT → mem_req_o low next cycle, no pready_o, err_sticky_o=1 until rst_i. rst_i asserted mid-MEM_WAIT → all outputs 0 after the edge.
